// File: rtl/disp_scan_mux.sv
// disp_scan_mux: four-digit common-anode seven-segment scanner.
// Shadow/display register pair keeps every frame coherent across updates.
module disp_scan_mux #(
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic        lz_blank,
  output logic        ack,
  output logic [3:0]  hex,
  output logic        dp,
  output logic [3:0]  an
);

  localparam int MAXC = (DIGIT_CYCLES > BLANK_CYCLES) ?
                        DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] DIGIT_LAST = CW'(DIGIT_CYCLES - 1);

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    digit_q, digit_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          pending_q, pending_d;
  logic [15:0]   sh_val_q, sh_val_d;
  logic [3:0]    sh_dp_q, sh_dp_d;
  logic          sh_lzb_q, sh_lzb_d;

  logic [15:0]   d_val_q, d_val_d;
  logic [3:0]    d_dp_q, d_dp_d;
  logic          d_lzb_q, d_lzb_d;

  logic          ack_q, ack_d;
  logic [3:0]    hex_q, hex_d;
  logic          dp_q, dp_d;
  logic [3:0]    an_q, an_d;

  logic          blank_end;
  logic          show_end;
  logic          xfer;
  logic          z3, z32, z321;
  logic          sup;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= BLANK;
      digit_q   <= 2'd0;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      sh_val_q  <= 16'h0000;
      sh_dp_q   <= 4'hF;
      sh_lzb_q  <= 1'b0;
      d_val_q   <= 16'h0000;
      d_dp_q    <= 4'hF;
      d_lzb_q   <= 1'b0;
      ack_q     <= 1'b0;
      hex_q     <= 4'h0;
      dp_q      <= 1'b1;
      an_q      <= 4'hF;
    end else begin
      state_q   <= state_d;
      digit_q   <= digit_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      sh_val_q  <= sh_val_d;
      sh_dp_q   <= sh_dp_d;
      sh_lzb_q  <= sh_lzb_d;
      d_val_q   <= d_val_d;
      d_dp_q    <= d_dp_d;
      d_lzb_q   <= d_lzb_d;
      ack_q     <= ack_d;
      hex_q     <= hex_d;
      dp_q      <= dp_d;
      an_q      <= an_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    digit_d   = digit_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    sh_val_d  = sh_val_q;
    sh_dp_d   = sh_dp_q;
    sh_lzb_d  = sh_lzb_q;
    d_val_d   = d_val_q;
    d_dp_d    = d_dp_q;
    d_lzb_d   = d_lzb_q;

    blank_end = (state_q == BLANK) && (cnt_q == BLANK_LAST);
    show_end  = (state_q == SHOW) && (cnt_q == DIGIT_LAST);

    unique case (state_q)
      BLANK: begin
        if (blank_end) begin
          state_d = SHOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SHOW: begin
        if (show_end) begin
          state_d = BLANK;
          cnt_d   = '0;
          digit_d = digit_q + 2'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase

    // Only a frame start may swap display data; a same-cycle load wins.
    xfer = blank_end && (digit_q == 2'd0) && (pending_q || load);

    if (xfer) begin
      pending_d = 1'b0;
      if (load) begin
        d_val_d = value;
        d_dp_d  = dp_in;
        d_lzb_d = lz_blank;
      end else begin
        d_val_d = sh_val_q;
        d_dp_d  = sh_dp_q;
        d_lzb_d = sh_lzb_q;
      end
    end else if (load) begin
      pending_d = 1'b1;
      sh_val_d  = value;
      sh_dp_d   = dp_in;
      sh_lzb_d  = lz_blank;
    end
  end

  always_comb begin
    ack_d = xfer;
    hex_d = hex_q;
    dp_d  = 1'b1;
    an_d  = 4'hF;

    z3   = (d_val_d[15:12] == 4'h0);
    z32  = z3 && (d_val_d[11:8] == 4'h0);
    z321 = z32 && (d_val_d[7:4] == 4'h0);

    unique case (digit_d)
      2'd3:    sup = d_lzb_d && z3;
      2'd2:    sup = d_lzb_d && z32;
      2'd1:    sup = d_lzb_d && z321;
      default: sup = 1'b0;
    endcase

    // Suppressed digits still carry their nibble so hex stays predictable.
    if (state_d == SHOW) begin
      hex_d = d_val_d[{digit_d, 2'b00} +: 4];
      if (!sup) begin
        dp_d = d_dp_d[digit_d];
        an_d = ~(4'b0001 << digit_d);
      end
    end
  end

  assign ack = ack_q;
  assign hex = hex_q;
  assign dp  = dp_q;
  assign an  = an_q;

endmodule

// File: tb/tb_disp_scan_mux.sv
// tb_disp_scan_mux: directed bench with an expected-frame queue.
// Expected frames are built from the loaded value when load is driven.
module tb_disp_scan_mux;

  logic        clk;
  logic        reset;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        lz_blank;
  logic        ack;
  logic [3:0]  hex;
  logic        dp;
  logic [3:0]  an;

  typedef struct packed {
    logic       ack;
    logic [3:0] an;
    logic [3:0] hex;
    logic       dp;
  } exp_t;

  exp_t sb[$];
  int   tests;
  int   fails;

  disp_scan_mux #(
    .DIGIT_CYCLES(4),
    .BLANK_CYCLES(2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .value   (value),
    .dp_in   (dp_in),
    .lz_blank(lz_blank),
    .ack     (ack),
    .hex     (hex),
    .dp      (dp),
    .an      (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [9:0] obs,
                     input logic [9:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] obs_now();
    return {ack, an, hex, dp};
  endfunction

  // One frame starting at digit 0's first lit cycle; last load wins.
  task automatic push_frame(input logic [15:0] v, input logic [3:0] dpi,
                            input logic lzb, input logic a);
    exp_t e;
    logic sup;
    logic [3:0] nib;
    sb.delete();
    for (int k = 0; k < 4; k++) begin
      sup = lzb && (k != 0) && ((v >> (4 * k)) == 16'd0);
      nib = v[4 * k +: 4];
      for (int t = 0; t < 4; t++) begin
        e.ack = (k == 0 && t == 0) ? a : 1'b0;
        e.an  = sup ? 4'hF : ~(4'b0001 << k);
        e.hex = nib;
        e.dp  = sup ? 1'b1 : dpi[k];
        sb.push_back(e);
      end
      for (int t = 0; t < 2; t++) begin
        e.ack = 1'b0;
        e.an  = 4'hF;
        e.hex = nib;
        e.dp  = 1'b1;
        sb.push_back(e);
      end
    end
  endtask

  task automatic check_frame(input string tag);
    exp_t e;
    for (int i = 0; i < 24; i++) begin
      if (sb.size() == 0) begin
        chk($sformatf("%s_sb_empty[%0d]", tag, i), 10'(sb.size()), 10'd1);
      end else begin
        e = sb.pop_front();
        chk($sformatf("%s[%0d]", tag, i), obs_now(), e);
      end
      step();
    end
  endtask

  task automatic wait_ack(input string tag, input int max);
    for (int i = 0; i < max && ack !== 1'b1; i++) step();
    chk(tag, {9'd0, ack}, 10'd1);
  endtask

  task automatic wait_an(input string tag, input logic [3:0] pat,
                         input int max);
    for (int i = 0; i < max && an !== pat; i++) step();
    chk(tag, {6'd0, an}, {6'd0, pat});
  endtask

  task automatic drive_load(input logic [15:0] v, input logic [3:0] dpi,
                            input logic lzb);
    load     = 1'b1;
    value    = v;
    dp_in    = dpi;
    lz_blank = lzb;
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    reset    = 1'b1;
    load     = 1'b0;
    value    = 16'h0000;
    dp_in    = 4'hF;
    lz_blank = 1'b0;
    step();
    step();
    chk("rst_state", obs_now(), {1'b0, 4'hF, 4'h0, 1'b1});
    reset = 1'b0;
    step();
    chk("post_rst_blank", obs_now(), {1'b0, 4'hF, 4'h0, 1'b1});
    step();
    push_frame(16'h0000, 4'hF, 1'b0, 1'b0);
    check_frame("f0");

    // Load during digit 2; digits 2 and 3 keep old data.
    wait_an("t2_reach_d2", 4'b1011, 30);
    drive_load(16'h1A3F, 4'b1011, 1'b0);
    push_frame(16'h1A3F, 4'b1011, 1'b0, 1'b1);
    step();
    load = 1'b0;
    chk("t2_old_d2", obs_now(), {1'b0, 4'b1011, 4'h0, 1'b1});
    wait_an("t2_reach_d3", 4'b0111, 30);
    chk("t2_old_d3", obs_now(), {1'b0, 4'b0111, 4'h0, 1'b1});
    wait_ack("t2_ack", 40);
    check_frame("t2");

    drive_load(16'h0050, 4'hF, 1'b1);
    push_frame(16'h0050, 4'hF, 1'b1, 1'b1);
    step();
    load = 1'b0;
    wait_ack("t3a_ack", 40);
    check_frame("t3a");

    drive_load(16'h0000, 4'hF, 1'b1);
    push_frame(16'h0000, 4'hF, 1'b1, 1'b1);
    step();
    load = 1'b0;
    wait_ack("t3b_ack", 40);
    check_frame("t3b");

    // Two loads before the boundary: only the second is shown.
    drive_load(16'h1111, 4'hF, 1'b0);
    push_frame(16'h1111, 4'hF, 1'b0, 1'b1);
    step();
    load = 1'b0;
    step();
    step();
    drive_load(16'h2222, 4'hF, 1'b0);
    push_frame(16'h2222, 4'hF, 1'b0, 1'b1);
    step();
    load = 1'b0;
    wait_ack("t4_ack", 40);
    check_frame("t4");

    // Load on the exact digit-0 boundary while 1234 is pending.
    drive_load(16'h1234, 4'hF, 1'b0);
    push_frame(16'h1234, 4'hF, 1'b0, 1'b1);
    step();
    load = 1'b0;
    wait_an("t5_reach_d3", 4'b0111, 30);
    for (int i = 0; i < 5; i++) step();
    drive_load(16'hBEEF, 4'b1110, 1'b0);
    push_frame(16'hBEEF, 4'b1110, 1'b0, 1'b1);
    step();
    load = 1'b0;
    check_frame("t5");

    for (int f = 0; f < 3; f++) begin
      push_frame(16'hBEEF, 4'b1110, 1'b0, 1'b0);
      check_frame($sformatf("t6_f%0d", f));
    end

    // Asynchronous reset mid-SHOW; a load during reset is ignored.
    step();
    step();
    #1;
    reset = 1'b1;
    drive_load(16'h9999, 4'h0, 1'b0);
    #1;
    chk("t1_async", obs_now(), {1'b0, 4'hF, 4'h0, 1'b1});
    step();
    step();
    reset = 1'b0;
    load  = 1'b0;
    chk("t1_rst_hold", obs_now(), {1'b0, 4'hF, 4'h0, 1'b1});
    step();
    chk("t1_blank", obs_now(), {1'b0, 4'hF, 4'h0, 1'b1});
    step();
    push_frame(16'h0000, 4'hF, 1'b0, 1'b0);
    check_frame("t1_after");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
